// File: rtl/controlador_atividades_if.sv
// Pet activity controller bus: buttons and death request in,
// one-hot state, remaining cycles, completion pulse and busy flag out.
interface controlador_atividades_if #(
  parameter int W = 8
);
  logic         b1;
  logic         b2;
  logic         morreu;
  logic [3:0]   estado;
  logic [W-1:0] restante;
  logic         fim;
  logic         ocupado;

  modport master (
    output b1, b2, morreu,
    input  estado, restante, fim, ocupado
  );

  modport slave (
    input  b1, b2, morreu,
    output estado, restante, fim, ocupado
  );
endinterface

// File: rtl/controlador_atividades.sv
// Pet activity controller: button edge decode with combination window,
// timed activities, terminal death. Ports: clk, rst_n, bus (slave:
// b1/b2/morreu in; estado/restante/fim/ocupado out).
// Optional macro CONTROLADOR_INTERROMPE_EN: button edges abort activities.
module controlador_atividades #(
  parameter int W          = 8,
  parameter int DUR_COMER  = 10,
  parameter int DUR_DORMIR = 20,
  parameter int DUR_AULA   = 15,
  parameter int JANELA     = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  controlador_atividades_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;

  localparam logic [W-1:0] L_COMER  = W'(DUR_COMER - 1);
  localparam logic [W-1:0] L_DORMIR = W'(DUR_DORMIR - 1);
  localparam logic [W-1:0] L_AULA   = W'(DUR_AULA - 1);
  localparam logic [W-1:0] L_JAN    = W'(JANELA - 1);

  estado_t      st;
  logic [W-1:0] rest;
  logic [W-1:0] cnt;
  logic         fim_q;
  logic         b1_q;
  logic         b2_q;
  logic         pend;
  logic         pend_b2;
  logic         e1;
  logic         e2;
  logic         outra;

  assign e1 = bus.b1 & ~b1_q;
  assign e2 = bus.b2 & ~b2_q;
  // edge of the button that is not the pending one
  assign outra = pend_b2 ? e1 : e2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      rest    <= '0;
      cnt     <= '0;
      fim_q   <= 1'b0;
      b1_q    <= 1'b0;
      b2_q    <= 1'b0;
      pend    <= 1'b0;
      pend_b2 <= 1'b0;
    end else begin
      b1_q  <= bus.b1;
      b2_q  <= bus.b2;
      fim_q <= 1'b0;
      if (st == MORTO) begin
        st <= MORTO;
      end else if (bus.morreu) begin
        st   <= MORTO;
        rest <= '0;
        cnt  <= '0;
        pend <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (!pend) begin
              if (e1 && e2) begin
                st   <= DANDO_AULA;
                rest <= L_AULA;
              end else if (e1 || e2) begin
                pend    <= 1'b1;
                pend_b2 <= e2;
                cnt     <= L_JAN;
              end
            end else if (outra) begin
              st   <= DANDO_AULA;
              rest <= L_AULA;
              pend <= 1'b0;
            end else if (cnt == '0) begin
              st   <= pend_b2 ? DORMINDO : COMENDO;
              rest <= pend_b2 ? L_DORMIR : L_COMER;
              pend <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DORMINDO, COMENDO, DANDO_AULA: begin
`ifdef CONTROLADOR_INTERROMPE_EN
            if (e1 || e2) begin
              st   <= IDLE;
              rest <= '0;
            end else
`endif
            if (rest == '0) begin
              st    <= IDLE;
              fim_q <= 1'b1;
            end else begin
              rest <= rest - 1'b1;
            end
          end
          default: st <= st;
        endcase
      end
    end
  end

  assign bus.estado   = st;
  assign bus.restante = rest;
  assign bus.fim      = fim_q;
  assign bus.ocupado  = (st == DORMINDO) || (st == COMENDO)
                     || (st == DANDO_AULA);

endmodule

// File: doc/controlador_atividades.md
# controlador_atividades

Parametrised successor to the pet activity controller. It decodes the two user buttons with edge detection and a combination window, runs each activity for a configurable number of cycles, and returns to IDLE on its own. Death is terminal until reset. It sits between the button synchroniser and the display/needs logic, which consume `estado`, `restante` and `fim`.

## Interface
- `W`, 8: width of the duration and window counters.
- `DUR_COMER`, 10: cycles spent in COMENDO. Legal range 1..2^W.
- `DUR_DORMIR`, 20: cycles spent in DORMINDO. Legal range 1..2^W.
- `DUR_AULA`, 15: cycles spent in DANDO_AULA. Legal range 1..2^W.
- `JANELA`, 4: combination window in cycles. Legal range 1..2^W.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `b1` input 1: button 1, already synchronous to `clk`.
- `b2` input 1: button 2, already synchronous to `clk`.
- `morreu` input 1: death request, level, synchronous.
- `estado` output 4: one-hot state. IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000.
- `restante` output W: cycles left in the current activity, minus one. It is 0 outside activities.
- `fim` output 1: one-cycle pulse when an activity completes naturally.
- `ocupado` output 1: combinational; 1 when `estado` is DORMINDO, COMENDO or DANDO_AULA.

## Operation
- Edge detect: `e1 = b1 & !b1_q` and `e2 = b2 & !b2_q`, where `b1_q` and `b2_q` are the registered previous values. A held button never retriggers.
- IDLE, no pending press:
  - `e1 & e2` in the same cycle → DANDO_AULA.
  - `e1` alone → pending = b1, window counter loaded with JANELA-1.
  - `e2` alone → pending = b2, window counter loaded with JANELA-1.
- IDLE, pending press:
  - Edge of the other button → DANDO_AULA, pending cleared.
  - Otherwise, if counter == 0 → COMENDO when pending = b1, DORMINDO when pending = b2.
  - Otherwise, counter decrements.
  - A repeat edge of the pending button is ignored.
- Entering an activity loads `restante` with DUR_x-1.
- In an activity, each cycle:
  - `restante` == 0 → IDLE, `fim`=1 for one cycle.
  - Otherwise `restante` decrements.
- Button edges during an activity are ignored unless the macro in Configuration is defined.
- `morreu`=1 has top priority from any state → MORTO, with `restante`=0, pending cleared and no `fim`.
- MORTO is sticky. Buttons and `morreu` have no effect; only `rst_n` low leaves it.

## Timing
- Reset values: `estado`=0000 (IDLE), `restante`=0, `fim`=0, `ocupado`=0. `b1_q`, `b2_q`, the pending flag and the window counter are all cleared.
- Reset asserted mid-window or mid-activity clears everything immediately. After release, the first state change needs a fresh edge.
- A button held through reset release counts as an edge on the first clock.
- Single press detected at edge E → activity state from edge E+JANELA.
- Second button's edge detected at edge E+k (k < JANELA) → DANDO_AULA from edge E+k.
- Each activity holds `estado` for exactly DUR_x cycles. `fim` is high in the first IDLE cycle after the activity and `restante`=0 in that cycle.
- Completion and an edge in the same cycle: the edge is not captured into pending. IDLE needs a new edge.
- `morreu` and a completion in the same cycle → MORTO, `fim`=0.
- `morreu` and a window expiry in the same cycle → MORTO.

## Configuration
- `CONTROLADOR_INTERROMPE_EN` defined:
  - `e1` or `e2` during an activity → IDLE on the next edge, `restante`=0, `fim`=0.
  - That same edge is not captured as a new pending press.
- Not defined: button edges during activities are ignored and activities always run to completion.

## Test plan
Default parameters unless stated.
- Single press: `b1` rises and is sampled at edge 0 → COMENDO from edge 4 (`restante`=9), IDLE at edge 14 with `fim`=1 for one cycle.
- Combination: `b2` edge at edge 0, `b1` edge at edge 2 → DANDO_AULA from edge 2, IDLE plus `fim` after 15 cycles. Both edges at edge 0 → DANDO_AULA from edge 0.
- Held button: `b1` held for 40 cycles → exactly one COMENDO run, then IDLE with no retrigger.
- Death: `morreu`=1 at the 5th cycle of DORMINDO → MORTO next edge, `restante`=0, `fim`=0. Button presses then leave it in MORTO. `rst_n` low → IDLE asynchronously.
- Interrupt: `b2` edge at the 3rd cycle of COMENDO. With `CONTROLADOR_INTERROMPE_EN` → IDLE next edge, `fim`=0. Without it → COMENDO lasts the full 10 cycles.
- Reset mid-window: `b1` edge, then `rst_n` low for 1 cycle after 2 cycles → IDLE with no pending press, and no COMENDO follows.
